uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter: serializes one byte per accepted request into an 8-N-1 frame on `tx_out`, with a configurable bit period in clock cycles. Sits directly upstream of `uart_rx` on the serial line (and in loopback benches), using the same `baud` semantics as `uart_rx`: clocks per bit. Byte-wide producer side uses a valid/ready handshake. Completion is reported with a one-cycle pulse.

## Interface
- No parameters.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `baud` input 20: bit period in `clk` cycles; 0 is treated as 1.
- `tx_en` input 1: transmitter enable; gates acceptance of new bytes only.
- `tx_data` input 8: byte to send.
- `tx_valid` input 1: producer has a byte on `tx_data`.
- `tx_ready` output 1: block can accept a byte this cycle.
- `tx_out` output 1: serial line; idle high.
- `tx_busy` output 1: frame in progress.
- `tx_done` output 1: one-cycle pulse at end of frame.

## Operation
- FSM states:
  - IDLE
  - START
  - DATA
  - PARITY (only with macro)
  - STOP
- IDLE:
  - `tx_out`=1, `tx_busy`=0, `tx_ready`=`tx_en`.
  - Accept when `tx_valid && tx_ready` at an edge.
  - On accept, latch `tx_data` into the shift register and `baud` into the period register (0 -> 1), clear the bit counter and go to START.
- START: `tx_out`=0 for one bit period, then DATA.
- DATA:
  - 8 bits, LSB first, each one bit period; shift right after each bit.
  - After bit 7, go to PARITY if enabled, else STOP.
- STOP: `tx_out`=1 for one bit period, then IDLE with `tx_done`=1 for that single IDLE cycle.
- Bit timing: a 20-bit cycle counter runs 0..period-1 in every non-IDLE state. The state/bit advances when counter == period-1.
- `tx_busy`=1 in every non-IDLE state.
- `tx_ready`=0 in every non-IDLE state.
- Post-accept input changes:
  - Changes on `tx_data` or `baud` after accept have no effect on the current frame.
  - Deasserting `tx_en` mid-frame does not abort; the frame completes and no new byte is accepted while `tx_en`=0.
- `tx_out` is driven from a register; no combinational path from inputs.

## Timing
- Reset values:
  - `tx_out`=1
  - `tx_busy`=0
  - `tx_done`=0
  - `tx_ready`=0 during the reset cycle, then follows `tx_en`
  - state IDLE, counters cleared.
- Reset mid-frame: next edge forces IDLE and `tx_out`=1. No `tx_done` pulse.
- Accept at edge E:
  - `tx_out` falls at E+1.
  - Start bit occupies cycles E+1..E+P, where P is the latched period.
  - Data bit k occupies E+1+(k+1)P .. E+(k+2)P.
- Frame length: 10·P cycles (11·P with parity), from E+1.
- Frame end:
  - `tx_done` and `tx_ready` (if `tx_en`) are high in the cycle after the last stop-bit cycle.
  - A back-to-back accept in that cycle starts the next start bit one cycle later.
  - Minimum line-high gap between frames is therefore P+1 cycles.
- P=1: each bit lasts exactly one cycle. Counter never exceeds 0.
- `tx_valid` with `tx_en`=0: ignored, held off by `tx_ready`=0; no state change.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: PARITY state is inserted between DATA and STOP, driving even parity (XOR of the 8 latched data bits) for one bit period. Frame is 11·P cycles.
  - Undefined: no parity state, 8-N-1 only, frame is 10·P cycles. Parity logic is absent from the netlist.

## Test plan
- Reset, then idle:
  - Stimulus: `rst` high 2 cycles, `tx_en`=0, `tx_valid`=1.
  - Required: `tx_out`=1, `tx_ready`=0, `tx_busy`=0, `tx_done`=0 throughout.
- Single byte, no macro:
  - Stimulus: `baud`=20, `tx_en`=1, send 0x55.
  - Required: `tx_out` = 0 (start), 1,0,1,0,1,0,1,0, then 1 (stop), each bit exactly 20 cycles. One `tx_done` pulse at cycle 201 after accept.
- Back-to-back:
  - Stimulus: `baud`=4, `tx_valid` held high with 0x00 then 0xFF.
  - Required: second accept occurs in the `tx_done` cycle. Line high exactly 5 cycles between frames. `tx_busy` high 40 cycles per frame.
- Mid-frame disturbance:
  - Stimulus: `baud`=8, send 0x3C; change `tx_data`/`baud` and drop `tx_en` during bit 3.
  - Required: frame completes unchanged at 8 cycles/bit, and no further accept.
  - Stimulus: `rst` during DATA.
  - Required: `tx_out`=1 and IDLE on the next edge, with no `tx_done`.
- Parity, `UART_TX_PARITY_EN` defined:
  - Stimulus: `baud`=20, send 0xA7.
  - Required: bits 1,1,1,0,0,1,0,1, then parity 1, then stop. Frame is 220 cycles.
  - Stimulus: send 0x55.
  - Required: parity bit 0.
- Loopback:
  - Stimulus: `tx_out` wired to `uart_rx` `rx_in` with `sel`=1, `rx_en`=1, `baud`=20 on both; send 0x55, then 0xC3.
  - Required: `rx_data` = 0x55, then 0xC3.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: byte-wide valid/ready UART transmitter.
// The frame is 8-N-1. Define UART_TX_PARITY_EN to insert an even-parity bit (8-E-1).
// The bit period is 'baud' clk cycles. A baud value of 0 runs as 1.
// The period is latched when a byte is accepted.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   S_IDLE   | line high, ready when tx_en; tx_done pulses here after STOP
//   S_START  | start bit (line low) for one period
//   S_DATA   | 8 data bits LSB first, one period each
//   S_PARITY | even parity of the latched byte (UART_TX_PARITY_EN only)
//   S_STOP   | stop bit (line high) for one period
module uart_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] baud,
  input  logic        tx_en,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_out,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic [19:0] r_period;
  logic [19:0] r_cnt;
  logic [2:0]  r_bit;
  logic        r_tx_out;
  logic        r_done;
  logic        w_line_nxt;
  logic        w_ready;
  logic        w_accept;
  logic        w_tick;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  assign w_ready  = (r_state == S_IDLE) && tx_en && !rst;
  assign w_accept = tx_valid && w_ready;
  assign w_tick   = (r_cnt == (r_period - 20'd1));

  // State register plus the frame datapath (shifter, bit timer, line register)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= 8'd0;
      r_period <= 20'd1;
      r_cnt    <= 20'd0;
      r_bit    <= 3'd0;
      r_tx_out <= 1'b1;
      r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_tx_out <= w_line_nxt;
      r_done   <= (r_state == S_STOP) && w_tick;
      if (w_accept) begin
        r_period <= (baud == 20'd0) ? 20'd1 : baud;
        r_cnt    <= 20'd0;
        r_bit    <= 3'd0;
`ifdef UART_TX_PARITY_EN
        r_parity <= ^tx_data;
`endif
      end else if (r_state != S_IDLE) begin
        r_cnt <= w_tick ? 20'd0 : r_cnt + 20'd1;
        if ((r_state == S_DATA) && w_tick) r_bit <= r_bit + 3'd1;
      end
    end
  end

  // Next-state logic: every bit advances on the terminal count of the bit timer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_START;
      S_START:  if (w_tick) w_state_nxt = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (w_tick && (r_bit == 3'd7)) w_state_nxt = S_PARITY;
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
`else
      S_DATA:   if (w_tick && (r_bit == 3'd7)) w_state_nxt = S_STOP;
`endif
      S_STOP:   if (w_tick) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: the line value is computed for the next state, so tx_out comes straight from a flop
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_accept)
      w_shift_nxt = tx_data;
    else if ((r_state == S_DATA) && w_tick)
      w_shift_nxt = {1'b0, r_shift[7:1]};

    w_line_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_line_nxt = 1'b0;
      S_DATA:   w_line_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_line_nxt = r_parity;
`endif
      default:  w_line_nxt = 1'b1;
    endcase
  end

  assign tx_ready = w_ready;
  assign tx_out   = r_tx_out;
  assign tx_busy  = (r_state != S_IDLE);
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
// A frame is pushed to the queue at the accept edge and popped when the line is captured.
`timescale 1ns/1ps
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] baud = 20'd20;
  logic        tx_en = 1'b0;
  logic [7:0]  tx_data = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, tx_out, tx_busy, tx_done;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic [10:0] bits;
    int          p;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    logic [10:0] bits;
    int          glitches;
    int          busy_low;
    int          done_early;
    logic        done_end;
    logic        busy_end;
    logic        line_end;
    logic        ready_end;
  } obs_t;

  exp_t q_exp[$];

  always #5 clk = ~clk;

  uart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .baud     (baud),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  function automatic exp_t make_exp(input logic [7:0] d, input logic [19:0] b);
    exp_t e;
    e.bits = frame_of(d);
    e.p    = (b == 20'd0) ? 1 : int'(b);
    e.data = d;
    return e;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    if (q_exp.size() == 0) begin
      e.bits = 'x;
      e.p    = 1;
      e.data = 'x;
    end else begin
      e = q_exp.pop_front();
    end
    return e;
  endfunction

  // Waits for the accept edge, pushes the expected frame there, and returns #1 after that edge.
  task automatic send(input logic [7:0] d, input logic [19:0] b, input bit hold);
    bit got;
    tx_data  = d;
    baud     = b;
    tx_valid = 1'b1;
    got      = 1'b0;
    for (int w = 0; w < 2000; w++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: tx_ready stayed %b, required 1", tx_ready);
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    q_exp.push_back(make_exp(d, b));
    if (!hold) tx_valid = 1'b0;
  endtask

  // Records the line one cycle at a time from E+1 for NBITS*p cycles, then the cycle after the frame.
  task automatic capture(input int p, output obs_t o);
    o.bits       = '1;
    o.glitches   = 0;
    o.busy_low   = 0;
    o.done_early = 0;
    for (int n = 0; n < NBITS * p; n++) begin
      @(negedge clk);
      if ((n % p) == 0) o.bits[n / p] = tx_out;
      else if (tx_out !== o.bits[n / p]) o.glitches++;
      if (tx_busy !== 1'b1) o.busy_low++;
      if (tx_done !== 1'b0) o.done_early++;
    end
    @(negedge clk);
    o.done_end  = tx_done;
    o.busy_end  = tx_busy;
    o.line_end  = tx_out;
    o.ready_end = tx_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_en = 1'b0; tx_valid = 1'b1; tx_data = 8'h5A;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if ({tx_out, tx_ready, tx_busy, tx_done} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: out/ready/busy/done=%b, required 1000", c,
                 {tx_out, tx_ready, tx_busy, tx_done});
      end
    end
    @(posedge clk); #1; rst = 1'b0;
    begin
      int bad = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if ({tx_out, tx_ready, tx_busy, tx_done} !== 4'b1000) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL idle_en0: %0d cycles left idle with tx_en=0, required 0", bad);
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_single();
    exp_t e; obs_t o;
    tx_en = 1'b1;
    @(posedge clk); #1;
    send(8'h55, 20'd20, 1'b0);
    e = pop_exp();
    capture(e.p, o);
    n_tests++;
    if (o.bits[NBITS-1:0] !== e.bits[NBITS-1:0]) begin
      n_fail++;
      $display("FAIL single_bits: got %b, required %b", o.bits, e.bits);
    end
    n_tests++;
    if (o.glitches !== 0 || o.busy_low !== 0 || o.done_early !== 0) begin
      n_fail++;
      $display("FAIL single_timing: glitches=%0d busy_low=%0d done_early=%0d, required all 0",
               o.glitches, o.busy_low, o.done_early);
    end
    n_tests++;
    if ({o.done_end, o.busy_end, o.line_end, o.ready_end} !== 4'b1011) begin
      n_fail++;
      $display("FAIL single_done_at_201: done/busy/line/ready=%b, required 1011",
               {o.done_end, o.busy_end, o.line_end, o.ready_end});
    end
    @(negedge clk);
    n_tests++;
    if (tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_width: tx_done=%b one cycle later, required 0", tx_done);
    end
  endtask

  task automatic test_baud_zero();
    exp_t e; obs_t o;
    @(posedge clk); #1;
    send(8'hB4, 20'd0, 1'b0);
    e = pop_exp();
    capture(e.p, o);
    n_tests++;
    if (o.bits[NBITS-1:0] !== e.bits[NBITS-1:0] || o.busy_low !== 0) begin
      n_fail++;
      $display("FAIL baud0_bits: got %b busy_low=%0d, required %b busy_low=0", o.bits, o.busy_low, e.bits);
    end
    n_tests++;
    if (o.done_end !== 1'b1 || o.busy_end !== 1'b0) begin
      n_fail++;
      $display("FAIL baud0_done: done=%b busy=%b, required 1 0", o.done_end, o.busy_end);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; obs_t o;
    @(posedge clk); #1;
    send(8'h00, 20'd4, 1'b1);
    tx_data = 8'hFF;
    for (int f = 0; f < 2; f++) begin
      e = pop_exp();
      capture(e.p, o);
      n_tests++;
      if (o.bits[NBITS-1:0] !== e.bits[NBITS-1:0] || o.glitches !== 0) begin
        n_fail++;
        $display("FAIL b2b_bits f%0d: got %b glitches=%0d, required %b glitches=0", f, o.bits, o.glitches, e.bits);
      end
      n_tests++;
      if (o.busy_low !== 0 || o.busy_end !== 1'b0 || o.done_early !== 0) begin
        n_fail++;
        $display("FAIL b2b_busy f%0d: busy_low=%0d busy_end=%b, required 0 0", f, o.busy_low, o.busy_end);
      end
      n_tests++;
      if ({o.done_end, o.line_end, o.ready_end} !== 3'b111) begin
        n_fail++;
        $display("FAIL b2b_done_cycle f%0d: done/line/ready=%b, required 111", f,
                 {o.done_end, o.line_end, o.ready_end});
      end
      if (f == 0) begin
        @(posedge clk);
        q_exp.push_back(make_exp(8'hFF, 20'd4));
        #1;
        tx_valid = 1'b0;
      end
    end
  endtask

  task automatic test_disturb();
    exp_t e; obs_t o; int bad;
    @(posedge clk); #1;
    send(8'h3C, 20'd8, 1'b0);
    e = pop_exp();
    fork
      capture(e.p, o);
      begin
        repeat (4 * 8 + 1) @(negedge clk);
        #1;
        tx_data = 8'hFF; baud = 20'd3; tx_en = 1'b0; tx_valid = 1'b1;
      end
    join
    n_tests++;
    if (o.bits[NBITS-1:0] !== e.bits[NBITS-1:0] || o.glitches !== 0) begin
      n_fail++;
      $display("FAIL disturb_bits: got %b glitches=%0d, required %b glitches=0", o.bits, o.glitches, e.bits);
    end
    n_tests++;
    if (o.done_end !== 1'b1 || o.ready_end !== 1'b0 || o.busy_low !== 0) begin
      n_fail++;
      $display("FAIL disturb_end: done=%b ready=%b busy_low=%0d, required 1 0 0",
               o.done_end, o.ready_end, o.busy_low);
    end
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || tx_ready !== 1'b0 || tx_out !== 1'b1) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL disturb_no_accept: %0d bad cycles with tx_en=0, required 0", bad);
    end
    tx_valid = 1'b0; tx_en = 1'b1; baud = 20'd20;
  endtask

  task automatic test_reset_mid();
    exp_t e; obs_t o; int bad;
    @(posedge clk); #1;
    send(8'hA5, 20'd8, 1'b0);
    e = pop_exp();
    repeat (30) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({tx_out, tx_busy, tx_done, tx_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_mid_idle: out/busy/done/ready=%b, required 1000",
               {tx_out, tx_busy, tx_done, tx_ready});
    end
    @(posedge clk); #1; rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: %0d bad cycles, required 0", bad);
    end
    @(posedge clk); #1;
    send(8'h81, 20'd2, 1'b0);
    e = pop_exp();
    capture(e.p, o);
    n_tests++;
    if (o.bits[NBITS-1:0] !== e.bits[NBITS-1:0] || o.done_end !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got %b done=%b, required %b done=1", o.bits, o.done_end, e.bits);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    exp_t e; obs_t o;
    logic [7:0] bytes [2];
    bytes[0] = 8'hA7;
    bytes[1] = 8'h55;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      send(bytes[i], 20'd20, 1'b0);
      e = pop_exp();
      capture(e.p, o);
      n_tests++;
      if (o.bits !== e.bits || o.glitches !== 0) begin
        n_fail++;
        $display("FAIL parity_bits %h: got %b, required %b", bytes[i], o.bits, e.bits);
      end
      n_tests++;
      if (o.done_end !== 1'b1 || o.busy_low !== 0) begin
        n_fail++;
        $display("FAIL parity_len %h: done=%b busy_low=%0d, required done at 221", bytes[i], o.done_end, o.busy_low);
      end
    end
  endtask
`endif

  // Mid-bit sampling receiver, independent of capture().
  task automatic test_loopback();
    exp_t e; logic [7:0] rx; bit got; logic sb, stb;
    logic [7:0] bytes [2];
    bytes[0] = 8'h55;
    bytes[1] = 8'hC3;
    tx_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      send(bytes[i], 20'd20, 1'b0);
      e = pop_exp();
      got = 1'b0;
      for (int w = 0; w < 50; w++) begin
        @(negedge clk);
        if (tx_out === 1'b0) begin
          got = 1'b1;
          break;
        end
      end
      repeat (e.p / 2) @(negedge clk);
      sb = tx_out;
      rx = 8'd0;
      for (int k = 0; k < 8; k++) begin
        repeat (e.p) @(negedge clk);
        rx[k] = tx_out;
      end
      repeat ((NBITS - 9) * e.p) @(negedge clk);
      stb = tx_out;
      n_tests++;
      if (!got || sb !== 1'b0 || stb !== 1'b1) begin
        n_fail++;
        $display("FAIL loop_framing %0d: start_seen=%0d start=%b stop=%b, required 1 0 1", i, got, sb, stb);
      end
      n_tests++;
      if (rx !== e.data) begin
        n_fail++;
        $display("FAIL loop_data %0d: rx_data=%h, required %h", i, rx, e.data);
      end
      for (int w = 0; w < 200 && tx_busy; w++) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_baud_zero();
    test_back_to_back();
    test_disturb();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
